// File: rtl/da_slice_feeder_if.sv
// Sample stream in, DA-core slice handshake out; master = sample source plus DA core, slave = feeder.
// Carries no state, so it adds no latency; s_ready is the only backpressure signal.
interface da_slice_feeder_if #(
    parameter int SAMPLE_W = 16
);
    logic [SAMPLE_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic [7:0]          A0, A1, A2, A3, A4, A5, A6, A7;
    logic                start;
    logic                done;
    logic [3:0]          bit_idx;
    logic                sign_slice;
    logic                busy;
    logic                frame_done;

    modport master (
        output s_data, s_valid, done,
        input  s_ready, A0, A1, A2, A3, A4, A5, A6, A7,
        input  start, bit_idx, sign_slice, busy, frame_done
    );

    modport slave (
        input  s_data, s_valid, done,
        output s_ready, A0, A1, A2, A3, A4, A5, A6, A7,
        output start, bit_idx, sign_slice, busy, frame_done
    );
endinterface

// File: rtl/da_slice_feeder.sv
// Keeps a 64-tap sample history and feeds its bit slices to a DA core, MSB first, with one start pulse per slice.
// The first start comes 1 cycle after accept; s_ready is high only in IDLE, so the source stalls for the whole frame.
module da_slice_feeder #(
    parameter int SAMPLE_W = 16
) (
    input logic              clk,
    input logic              resetn,
    da_slice_feeder_if.slave bus
);
    localparam int         NTAPS   = 64;
    localparam logic [3:0] MSB_IDX = 4'(SAMPLE_W - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, FIN} state_t;

    state_t              state_q, state_d;
    logic [3:0]          bit_idx_q, bit_idx_d;
    logic [SAMPLE_W-1:0] dly_q [NTAPS];
    logic [7:0]          addr [8];
    logic                ready_c, start_c, fin_c, busy_c;
    logic                accept;

    assign accept = bus.s_valid && ready_c;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            bit_idx_q <= MSB_IDX;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NTAPS; i++) begin
                dly_q[i] <= '0;
            end
        end else if (accept) begin
            dly_q[0] <= bus.s_data;
            for (int i = 1; i < NTAPS; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    // WAIT_LO must see done low before WAIT_HI trusts a high level, so a level left over from the previous slice is ignored.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        ready_c   = 1'b0;
        start_c   = 1'b0;
        fin_c     = 1'b0;
        busy_c    = 1'b1;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                busy_c  = 1'b0;
                if (bus.s_valid) begin
                    state_d   = ISSUE;
                    bit_idx_d = MSB_IDX;
                end
            end
            ISSUE: begin
                start_c = 1'b1;
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!bus.done) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.done) begin
                    if (bit_idx_q == 4'd0) begin
                        state_d = FIN;
                    end else begin
                        state_d   = ISSUE;
                        bit_idx_d = bit_idx_q - 4'd1;
                    end
                end
            end
            FIN: begin
                fin_c   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address k, bit j is bit bit_idx of tap 8k+j.
    always_comb begin
        addr = '{default: '0};
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) begin
                addr[k][j] = dly_q[8*k + j][bit_idx_q];
            end
        end
    end

    assign bus.s_ready    = resetn && ready_c;
    assign bus.start      = resetn && start_c;
    assign bus.frame_done = resetn && fin_c;
    assign bus.busy       = resetn && busy_c;
    assign bus.sign_slice = resetn && busy_c && (bit_idx_q == MSB_IDX);
    assign bus.bit_idx    = resetn ? bit_idx_q : 4'd0;
    assign bus.A0         = resetn ? addr[0] : 8'd0;
    assign bus.A1         = resetn ? addr[1] : 8'd0;
    assign bus.A2         = resetn ? addr[2] : 8'd0;
    assign bus.A3         = resetn ? addr[3] : 8'd0;
    assign bus.A4         = resetn ? addr[4] : 8'd0;
    assign bus.A5         = resetn ? addr[5] : 8'd0;
    assign bus.A6         = resetn ? addr[6] : 8'd0;
    assign bus.A7         = resetn ? addr[7] : 8'd0;
endmodule

// File: tb/tb_da_slice_feeder.sv
// Bench for da_slice_feeder: a table of frames, hand-written corner sequences and random frames.
// Each slice is checked against a sample-history model, and a DA-core model answers every start.
module tb_da_slice_feeder;
    localparam int SW = 16;

    typedef struct {
        logic        rst;
        logic [15:0] smp;
        int          lat;
        logic [7:0]  a0_hi;
        logic [7:0]  a0_lo;
        logic [7:0]  a1_lo;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    logic core_auto = 1'b1;
    logic core_done;
    logic man_done;
    int   core_lat = 3;
    int   nchecks = 0;
    int   nerr = 0;

    logic [SW-1:0] hist [$];
    logic          in_frame = 1'b0;
    int            exp_bit = SW - 1;
    int            nstarts = 0;
    logic          low_seen = 1'b0;
    logic          rise_seen = 1'b0;
    logic [63:0]   snap_a = '0;
    logic [3:0]    snap_bit = '0;
    int            acc_cnt = 0;
    int            fd_cnt = 0;
    int            start_cnt = 0;
    int            wrap_cnt = 0;
    logic [7:0]    cap_a0_hi = '0;
    logic [7:0]    cap_a0_lo = '0;
    logic [7:0]    cap_a1_lo = '0;

    da_slice_feeder_if #(.SAMPLE_W(SW)) bus ();
    assign bus.done = core_auto ? core_done : man_done;

    da_slice_feeder #(.SAMPLE_W(SW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_a_all();
        return {bus.A7, bus.A6, bus.A5, bus.A4, bus.A3, bus.A2, bus.A1, bus.A0};
    endfunction

    // Address k collects bit b of the samples accepted 8k..8k+7 accepts ago.
    function automatic logic [7:0] exp_addr(input int k, input int b);
        logic [7:0]    r;
        logic [SW-1:0] s;
        r = '0;
        if (b < 0 || b >= SW) return r;
        for (int j = 0; j < 8; j++) begin
            s    = hist[8*k + j];
            r[j] = s[b];
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_addr_all(input int b);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = exp_addr(k, b);
        return r;
    endfunction

    task automatic clear_history();
        hist.delete();
        for (int i = 0; i < 64; i++) hist.push_back('0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_pt();
        @(negedge clk);
        #1;
    endtask

    // Monitor: scores every slice and frame against the history model.
    initial begin
        clear_history();
        forever begin
            @(negedge clk);
            if (!resetn) begin
                check("rst_ctrl_outputs", {bus.start, bus.frame_done, bus.busy, bus.s_ready, bus.sign_slice}, 0);
                check("rst_addr_outputs", dut_a_all(), 0);
                clear_history();
                in_frame = 1'b0;
            end else begin
                check("ready_vs_busy", bus.s_ready, !bus.busy);
                check("start_fd_exclusive", bus.start & bus.frame_done, 0);
                if (bus.start) begin
                    start_cnt++;
                    check("start_in_frame", in_frame, 1);
                    check("slice_bit_idx", bus.bit_idx, exp_bit);
                    check("slice_sign", bus.sign_slice, exp_bit == SW - 1);
                    if (nstarts > 0) check("done_handshake", rise_seen, 1);
                    check("slice_addr", dut_a_all(), exp_addr_all(exp_bit));
                    if (dut_a_all() == 64'hFFFF_FFFF_FFFF_FFFE) wrap_cnt++;
                    if (exp_bit == SW - 1) cap_a0_hi = bus.A0;
                    if (exp_bit == 0) begin
                        cap_a0_lo = bus.A0;
                        cap_a1_lo = bus.A1;
                    end
                    snap_a    = dut_a_all();
                    snap_bit  = bus.bit_idx;
                    low_seen  = 1'b0;
                    rise_seen = 1'b0;
                    nstarts++;
                    exp_bit--;
                end else if (in_frame) begin
                    if (bus.busy) begin
                        check("slice_hold_addr", dut_a_all(), snap_a);
                        check("slice_hold_bit", bus.bit_idx, snap_bit);
                    end
                    if (!bus.done) low_seen = 1'b1;
                    else if (low_seen) rise_seen = 1'b1;
                end
                if (bus.frame_done) begin
                    fd_cnt++;
                    check("fd_in_frame", in_frame, 1);
                    check("fd_start_count", nstarts, SW);
                    in_frame = 1'b0;
                end
                if (bus.s_valid && bus.s_ready) begin
                    acc_cnt++;
                    hist.push_front(bus.s_data);
                    void'(hist.pop_back());
                    in_frame  = 1'b1;
                    exp_bit   = SW - 1;
                    nstarts   = 0;
                    low_seen  = 1'b0;
                    rise_seen = 1'b0;
                end
            end
        end
    end

    // DA core model: done drops on start and rises core_lat cycles later, then stays high.
    initial begin
        int cnt;
        cnt       = 0;
        core_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!core_auto) begin
                core_done = 1'b0;
                cnt       = 0;
            end else if (bus.start) begin
                core_done = 1'b0;
                cnt       = core_lat;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) core_done = 1'b1;
            end
        end
    end

    task automatic do_reset();
        tick();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        sample_pt();
        check("ready_after_reset", bus.s_ready, 1);
    endtask

    task automatic accept_one(input logic [SW-1:0] smp);
        int a0;
        int n;
        a0 = acc_cnt;
        n  = 0;
        tick();
        bus.s_data  = smp;
        bus.s_valid = 1'b1;
        do begin
            sample_pt();
            n++;
        end while (acc_cnt == a0 && n < 20);
        check("accept_timeout", acc_cnt != a0, 1);
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_fd(input int f0, input int budget);
        int n;
        n = 0;
        while (fd_cnt == f0 && n < budget) begin
            sample_pt();
            n++;
        end
        check("frame_timeout", fd_cnt != f0, 1);
    endtask

    task automatic wait_start(output logic got);
        int n;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            sample_pt();
            n++;
            got = bus.start;
        end
    endtask

    task automatic run_frame(input logic [SW-1:0] smp, input int lat);
        int f0;
        core_lat = lat;
        f0 = fd_cnt;
        accept_one(smp);
        wait_fd(f0, SW * (lat + 4) + 20);
    endtask

    // done held high across every slice: each WAIT_LO must stall until done is pulled low.
    task automatic scen_stuck_done();
        int   f0;
        logic got;
        tick();
        core_auto = 1'b0;
        man_done  = 1'b1;
        f0 = fd_cnt;
        accept_one(16'h5A3C);
        for (int s = 0; s < SW; s++) begin
            wait_start(got);
            check("stuck_start_timeout", got, 1);
            for (int c = 0; c < 4; c++) begin
                sample_pt();
                check("stall_no_start", bus.start, 0);
                check("stall_busy", bus.busy, 1);
            end
            tick();
            man_done = 1'b0;
            tick();
            man_done = 1'b1;
        end
        wait_fd(f0, 20);
        man_done  = 1'b0;
        core_auto = 1'b1;
    endtask

    // s_valid never drops: exactly one accept per frame, the next one straight after FIN.
    task automatic scen_valid_held();
        int a0;
        int f0;
        a0 = acc_cnt;
        f0 = fd_cnt;
        core_lat = 2;
        tick();
        bus.s_data  = 16'h1357;
        bus.s_valid = 1'b1;
        wait_fd(f0, 200);
        check("held_one_accept", acc_cnt - a0, 1);
        sample_pt();
        check("held_ready_after_fin", bus.s_ready, 1);
        check("held_second_accept", acc_cnt - a0, 2);
        tick();
        bus.s_valid = 1'b0;
        wait_fd(f0 + 1, 200);
    endtask

    // One-cycle reset during WAIT_HI of bit 7, with done held high through and after reset.
    task automatic scen_mid_reset();
        int   n;
        int   s0;
        int   f0;
        logic got;
        core_lat = 4;
        accept_one(16'hC3A5);
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            sample_pt();
            n++;
            got = bus.start && (bus.bit_idx == 4'd7);
        end
        check("midrst_bit7_timeout", got, 1);
        tick();
        tick();
        s0 = start_cnt;
        f0 = fd_cnt;
        resetn    = 1'b0;
        core_auto = 1'b0;
        man_done  = 1'b1;
        tick();
        resetn = 1'b1;
        sample_pt();
        check("midrst_ready", bus.s_ready, 1);
        check("midrst_idle_outputs", {bus.busy, bus.start, bus.frame_done, bus.sign_slice}, 0);
        check("midrst_addr_clear", dut_a_all(), 0);
        check("midrst_bit_idx", bus.bit_idx, SW - 1);
        repeat (6) sample_pt();
        check("midrst_no_start", start_cnt - s0, 0);
        check("midrst_no_fd", fd_cnt - f0, 0);
        man_done  = 1'b0;
        core_auto = 1'b1;
        run_frame(16'h0F0F, 3);
    endtask

    initial begin
        vec_t tbl [11];
        int   w0;
        resetn      = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        man_done    = 1'b0;

        tbl[0]  = '{1'b1, 16'h8001, 3, 8'h01, 8'h01, 8'h00};
        tbl[1]  = '{1'b1, 16'h0001, 2, 8'h00, 8'h01, 8'h00};
        tbl[2]  = '{1'b0, 16'h0002, 3, 8'h00, 8'h02, 8'h00};
        tbl[3]  = '{1'b0, 16'h0003, 4, 8'h00, 8'h05, 8'h00};
        tbl[4]  = '{1'b0, 16'h0004, 2, 8'h00, 8'h0A, 8'h00};
        tbl[5]  = '{1'b0, 16'h0005, 5, 8'h00, 8'h15, 8'h00};
        tbl[6]  = '{1'b0, 16'h0006, 3, 8'h00, 8'h2A, 8'h00};
        tbl[7]  = '{1'b0, 16'h0007, 2, 8'h00, 8'h55, 8'h00};
        tbl[8]  = '{1'b0, 16'h0008, 6, 8'h00, 8'hAA, 8'h00};
        tbl[9]  = '{1'b0, 16'h0009, 3, 8'h00, 8'h55, 8'h01};
        tbl[10] = '{1'b0, 16'hFFFF, 2, 8'h01, 8'hAB, 8'h02};

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) do_reset();
            run_frame(tbl[i].smp, tbl[i].lat);
            check("tbl_a0_msb_slice", cap_a0_hi, tbl[i].a0_hi);
            check("tbl_a0_lsb_slice", cap_a0_lo, tbl[i].a0_lo);
            check("tbl_a1_lsb_slice", cap_a1_lo, tbl[i].a1_lo);
        end

        scen_stuck_done();
        scen_valid_held();
        scen_mid_reset();

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            run_frame(16'($urandom), int'($urandom_range(2, 6)));
        end

        for (int i = 0; i < 64; i++) run_frame(16'hFFFF, 2);
        w0 = wrap_cnt;
        run_frame(16'h0000, 2);
        check("wrap_slices", wrap_cnt - w0, SW);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
